// File: rtl/uart_fifo_mmio_pkg.sv
// UART with TX/RX FIFOs behind a 4-word MMIO window.
// Shared register offsets, CON/STAT bit positions and FSM states.
package uart_fifo_mmio_pkg;

    localparam logic [3:0] OFF_TXD = 4'h0;
    localparam logic [3:0] OFF_RXD = 4'h4;
    localparam logic [3:0] OFF_CON = 4'h8;
    localparam logic [3:0] OFF_DIV = 4'hC;

    localparam int CON_TX_EN     = 0;
    localparam int CON_RX_EN     = 1;
    localparam int CON_TX_IRQ    = 2;
    localparam int CON_RX_IRQ    = 3;
    localparam int ST_TX_FULL    = 8;
    localparam int ST_TX_EMPTY   = 9;
    localparam int ST_RX_FULL    = 10;
    localparam int ST_RX_EMPTY   = 11;
    localparam int ST_OVERRUN    = 12;
    localparam int ST_FRAME_ERR  = 13;
    localparam int ST_RX_CNT_LSB = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } uart_state_t;

endpackage

// File: rtl/uart_fifo_mmio_if.sv
// Simple single-cycle MMIO bus: rd/wr strobes, byte address,
// write data and combinational read data.
interface uart_fifo_mmio_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output rd, wr, addr, wdata,
        input  rdata
    );

    modport slave (
        input  rd, wr, addr, wdata,
        output rdata
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO; push while full is accepted only
// when a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | pop);
    assign dout    = mem[rp];

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/uart_fifo_mmio.sv
// UART core: register window, TX/RX FIFOs, TX and RX bit engines.
// Bit timing reloads from DIV at every bit start.
module uart_fifo_mmio #(
    parameter logic [31:0] BASE_ADDR  = 32'h40000018,
    parameter int          FIFO_DEPTH = 8,
    parameter int          CLK_DIV    = 16
) (
    input  logic              cpu_clk,
    input  logic              reset,
    uart_fifo_mmio_if.slave   bus,
    input  logic              uart_rx,
    output logic              uart_tx,
    output logic              irq
);
    import uart_fifo_mmio_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0] off;
    logic [3:0]  reg_off;
    logic        hit, wr_en, rd_en;
    logic        sel_txd, sel_rxd, sel_con, sel_div;
    logic [3:0]  con;
    logic [15:0] div;
    logic [7:0]  txd_shadow;
    logic        overrun, frame_err;
    logic [31:0] stat;

    logic          tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]    tx_dout;
    logic [CW-1:0] tx_count;
    logic          rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]    rx_dout;
    logic [CW-1:0] rx_count;

    assign off     = bus.addr - BASE_ADDR;
    assign hit     = (off[31:4] == 28'd0);
    assign reg_off = {off[3:2], 2'b00};
    assign wr_en   = bus.wr & hit;
    assign rd_en   = bus.rd & ~bus.wr & hit;
    assign sel_txd = (reg_off == OFF_TXD);
    assign sel_rxd = (reg_off == OFF_RXD);
    assign sel_con = (reg_off == OFF_CON);
    assign sel_div = (reg_off == OFF_DIV);

    assign tx_push = wr_en & sel_txd;
    assign rx_pop  = rd_en & sel_rxd & ~rx_empty;

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(cpu_clk), .reset(reset),
        .push(tx_push), .pop(tx_pop), .din(bus.wdata[7:0]),
        .dout(tx_dout), .full(tx_full), .empty(tx_empty),
        .count(tx_count)
    );

    logic [7:0] rx_sh;

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(cpu_clk), .reset(reset),
        .push(rx_push), .pop(rx_pop), .din(rx_sh),
        .dout(rx_dout), .full(rx_full), .empty(rx_empty),
        .count(rx_count)
    );

    always_comb begin
        stat = '0;
        stat[3:0]          = con;
        stat[ST_TX_FULL]   = tx_full;
        stat[ST_TX_EMPTY]  = tx_empty;
        stat[ST_RX_FULL]   = rx_full;
        stat[ST_RX_EMPTY]  = rx_empty;
        stat[ST_OVERRUN]   = overrun;
        stat[ST_FRAME_ERR] = frame_err;
        stat[ST_RX_CNT_LSB +: 8] = 8'(rx_count);
    end

    always_comb begin
        bus.rdata = '0;
        if (rd_en) begin
            unique case (1'b1)
                sel_txd: bus.rdata = {24'd0, txd_shadow};
                sel_rxd: bus.rdata = rx_empty ? 32'd0 : {24'd0, rx_dout};
                sel_con: bus.rdata = stat;
                sel_div: bus.rdata = {16'd0, div};
            endcase
        end
    end

    // TX engine
    uart_state_t tx_state;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_sh;
    logic        tx_done;

    assign tx_done = (tx_cnt == 16'd0);
    assign tx_pop  = con[CON_TX_EN] & ~tx_empty &
                     ((tx_state == S_IDLE) |
                      ((tx_state == S_STOP) & tx_done));

    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            tx_state <= S_IDLE;
            uart_tx  <= 1'b1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
        end else begin
            unique case (tx_state)
                S_IDLE: if (tx_pop) begin
                    tx_state <= S_START;
                    uart_tx  <= 1'b0;
                    tx_sh    <= tx_dout;
                    tx_cnt   <= div - 16'd1;
                end
                S_START: if (tx_done) begin
                    tx_state <= S_DATA;
                    uart_tx  <= tx_sh[0];
                    tx_sh    <= tx_sh >> 1;
                    tx_bit   <= '0;
                    tx_cnt   <= div - 16'd1;
                end else tx_cnt <= tx_cnt - 16'd1;
                S_DATA: if (tx_done) begin
                    tx_cnt <= div - 16'd1;
                    if (tx_bit == 3'd7) begin
                        tx_state <= S_STOP;
                        uart_tx  <= 1'b1;
                    end else begin
                        tx_bit  <= tx_bit + 3'd1;
                        uart_tx <= tx_sh[0];
                        tx_sh   <= tx_sh >> 1;
                    end
                end else tx_cnt <= tx_cnt - 16'd1;
                S_STOP: if (tx_done) begin
                    if (tx_pop) begin
                        tx_state <= S_START;
                        uart_tx  <= 1'b0;
                        tx_sh    <= tx_dout;
                        tx_cnt   <= div - 16'd1;
                    end else tx_state <= S_IDLE;
                end else tx_cnt <= tx_cnt - 16'd1;
            endcase
        end
    end

    // RX engine
    uart_state_t rx_state;
    logic        rx_s1, rx_s2, rx_prev;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic        rx_done, rx_fall, rx_stop_hit;
    logic        rx_ovr, rx_ferr;

    assign rx_done     = (rx_cnt == 16'd0);
    assign rx_fall     = rx_prev & ~rx_s2;
    assign rx_stop_hit = (rx_state == S_STOP) & rx_done;
    assign rx_push     = rx_stop_hit & rx_s2;
    assign rx_ovr      = rx_push & rx_full & ~rx_pop;
    assign rx_ferr     = rx_stop_hit & ~rx_s2;

    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            unique case (rx_state)
                S_IDLE: if (con[CON_RX_EN] & rx_fall) begin
                    rx_state <= S_START;
                    rx_cnt   <= {1'b0, div[15:1]} - 16'd1;
                end
                S_START: if (rx_done) begin
                    rx_state <= rx_s2 ? S_IDLE : S_DATA;
                    rx_bit   <= '0;
                    rx_cnt   <= div - 16'd1;
                end else rx_cnt <= rx_cnt - 16'd1;
                S_DATA: if (rx_done) begin
                    rx_sh  <= {rx_s2, rx_sh[7:1]};
                    rx_cnt <= div - 16'd1;
                    if (rx_bit == 3'd7) rx_state <= S_STOP;
                    else rx_bit <= rx_bit + 3'd1;
                end else rx_cnt <= rx_cnt - 16'd1;
                S_STOP: if (rx_done) rx_state <= S_IDLE;
                else rx_cnt <= rx_cnt - 16'd1;
            endcase
        end
    end

    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            con        <= 4'h3;
            div        <= 16'(CLK_DIV);
            txd_shadow <= '0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (tx_push & (~tx_full | tx_pop)) txd_shadow <= bus.wdata[7:0];
            if (wr_en & sel_con) con <= bus.wdata[3:0];
            if (wr_en & sel_div)
                div <= (bus.wdata[15:0] < 16'd2) ? 16'd2 : bus.wdata[15:0];
            // a new error event wins over a same-cycle clear
            if (rx_ovr) overrun <= 1'b1;
            else if (wr_en & sel_con & bus.wdata[ST_OVERRUN]) overrun <= 1'b0;
            if (rx_ferr) frame_err <= 1'b1;
            else if (wr_en & sel_con & bus.wdata[ST_FRAME_ERR]) frame_err <= 1'b0;
        end
    end

    assign irq = (con[CON_TX_IRQ] & (tx_count == '0) & (tx_state == S_IDLE)) |
                 (con[CON_RX_IRQ] & ~rx_empty) | overrun | frame_err;

endmodule

// File: tb/tb_uart_fifo_mmio.sv
// Directed bench for uart_fifo_mmio with CLK_DIV=4, FIFO_DEPTH=4.
module tb_uart_fifo_mmio;

    localparam logic [31:0] BASE = 32'h40000018;
    localparam logic [31:0] A_TXD = BASE + 32'h0;
    localparam logic [31:0] A_RXD = BASE + 32'h4;
    localparam logic [31:0] A_CON = BASE + 32'h8;
    localparam logic [31:0] A_DIV = BASE + 32'hC;

    logic cpu_clk;
    logic reset;
    logic uart_rx;
    logic uart_tx;
    logic irq;

    int n_cmp = 0;
    int n_bad = 0;

    uart_fifo_mmio_if bus();

    uart_fifo_mmio #(
        .BASE_ADDR(BASE), .FIFO_DEPTH(4), .CLK_DIV(4)
    ) dut (
        .cpu_clk(cpu_clk),
        .reset(reset),
        .bus(bus.slave),
        .uart_rx(uart_rx),
        .uart_tx(uart_tx),
        .irq(irq)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge cpu_clk);
        bus.wr = 1'b1; bus.addr = a; bus.wdata = d;
        @(negedge cpu_clk);
        bus.wr = 1'b0; bus.wdata = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge cpu_clk);
        bus.rd = 1'b1; bus.addr = a;
        #1 d = bus.rdata;
        @(negedge cpu_clk);
        bus.rd = 1'b0;
    endtask

    task automatic expect_reg(input logic [31:0] a, input logic [31:0] exp,
                              input string name);
        logic [31:0] d;
        bus_read(a, d);
        n_cmp++;
        if (d !== exp) begin
            n_bad++;
            $display("FAIL %s: read %08h expected %08h", name, d, exp);
        end
    endtask

    task automatic expect_irq(input logic exp, input string name);
        n_cmp++;
        if (irq !== exp) begin
            n_bad++;
            $display("FAIL %s: irq=%b expected %b", name, irq, exp);
        end
    endtask

    // called on a negedge; returns on the negedge of the first low cycle
    task automatic wait_tx_start(input string name);
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (uart_tx === 1'b0) begin ok = 1; break; end
            @(negedge cpu_clk);
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: uart_tx start bit seen=0 expected 1", name);
        end
    endtask

    // checks 40 cycles from the current negedge (frame cycle 0)
    task automatic check_frame(input logic [7:0] b, input string name);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int i = 0; i < 40; i++) begin
            n_cmp++;
            if (uart_tx !== fr[i/4]) begin
                n_bad++;
                $display("FAIL %s cyc%0d: uart_tx=%b expected %b",
                         name, i, uart_tx, fr[i/4]);
            end
            @(negedge cpu_clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stopb);
        @(negedge cpu_clk); uart_rx = 1'b0;
        repeat (3) @(negedge cpu_clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge cpu_clk); uart_rx = b[i];
            repeat (3) @(negedge cpu_clk);
        end
        @(negedge cpu_clk); uart_rx = stopb;
        repeat (3) @(negedge cpu_clk);
        @(negedge cpu_clk); uart_rx = 1'b1;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        n_cmp++;
        if (uart_tx !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_tx: uart_tx=%b expected 1", uart_tx);
        end
        expect_irq(1'b0, "reset_irq");
        expect_reg(A_CON, 32'h00000A03, "reset_con");
        expect_reg(A_DIV, 32'd4, "reset_div");
        expect_reg(A_TXD, 32'd0, "reset_txd");
        expect_reg(BASE + 32'h10, 32'd0, "read_outside_hi");
        expect_reg(BASE - 32'h4, 32'd0, "read_outside_lo");
        @(negedge cpu_clk);
        bus.addr = A_CON; bus.rd = 1'b0;
        #1 d = bus.rdata;
        n_cmp++;
        if (d !== 32'd0) begin
            n_bad++;
            $display("FAIL rdata_idle: rdata=%08h expected 0", d);
        end
    endtask

    task automatic test_tx_frame;
        bus_write(A_TXD, 32'hA5);
        wait_tx_start("tx_a5_start");
        check_frame(8'hA5, "tx_a5");
        n_cmp++;
        if (uart_tx !== 1'b1) begin
            n_bad++;
            $display("FAIL tx_a5_idle: uart_tx=%b expected 1", uart_tx);
        end
        expect_reg(A_CON, 32'h00000A03, "tx_a5_con");
        expect_reg(A_TXD, 32'h000000A5, "tx_a5_txd");
    endtask

    task automatic test_back_to_back;
        int lows;
        bus_write(A_CON, 32'h2);
        @(negedge cpu_clk);
        for (int i = 1; i <= 5; i++) begin
            bus.wr = 1'b1; bus.addr = A_TXD; bus.wdata = 32'(i);
            @(negedge cpu_clk);
        end
        bus.wr = 1'b0;
        expect_reg(A_CON, 32'h00000902, "b2b_full");
        expect_reg(A_TXD, 32'h00000004, "b2b_shadow");
        bus_write(A_CON, 32'h3);
        wait_tx_start("b2b_start");
        for (int f = 1; f <= 4; f++) check_frame(8'(f), $sformatf("b2b_f%0d", f));
        lows = 0;
        for (int i = 0; i < 12; i++) begin
            if (uart_tx !== 1'b1) lows++;
            @(negedge cpu_clk);
        end
        n_cmp++;
        if (lows != 0) begin
            n_bad++;
            $display("FAIL b2b_no_fifth: low cycles=%0d expected 0", lows);
        end
        expect_reg(A_CON, 32'h00000A03, "b2b_empty");
    endtask

    task automatic test_rx;
        send_frame(8'h3C, 1'b1);
        repeat (6) @(negedge cpu_clk);
        expect_reg(A_CON, 32'h00010203, "rx_count1");
        expect_reg(A_RXD, 32'h0000003C, "rx_data");
        expect_reg(A_CON, 32'h00000A03, "rx_empty");
        expect_reg(A_RXD, 32'h00000000, "rx_read_empty");
        expect_reg(A_CON, 32'h00000A03, "rx_no_pop");
    endtask

    task automatic test_overrun;
        logic [7:0] v [5];
        v[0] = 8'h11; v[1] = 8'h22; v[2] = 8'h33; v[3] = 8'h44; v[4] = 8'h55;
        for (int i = 0; i < 5; i++) send_frame(v[i], 1'b1);
        repeat (6) @(negedge cpu_clk);
        expect_irq(1'b1, "ovr_irq");
        expect_reg(A_CON, 32'h00041603, "ovr_con");
        bus_write(A_CON, 32'h0003);
        expect_reg(A_CON, 32'h00041603, "ovr_keep");
        bus_write(A_CON, 32'h1003);
        expect_reg(A_CON, 32'h00040603, "ovr_clear");
        expect_irq(1'b0, "ovr_irq_off");
        bus_write(A_CON, 32'h000B);
        expect_irq(1'b1, "rx_irq_on");
        for (int i = 0; i < 4; i++)
            expect_reg(A_RXD, 32'(v[i]), $sformatf("ovr_rd%0d", i));
        expect_irq(1'b0, "rx_irq_drained");
        bus_write(A_CON, 32'h0003);
    endtask

    task automatic test_frame_err;
        send_frame(8'h5A, 1'b0);
        repeat (6) @(negedge cpu_clk);
        expect_reg(A_CON, 32'h00002A03, "ferr_con");
        expect_irq(1'b1, "ferr_irq");
        bus_write(A_CON, 32'h0003);
        expect_reg(A_CON, 32'h00002A03, "ferr_keep");
        bus_write(A_CON, 32'h2003);
        expect_reg(A_CON, 32'h00000A03, "ferr_clear");
        expect_irq(1'b0, "ferr_irq_off");
        @(negedge cpu_clk); uart_rx = 1'b0;
        @(negedge cpu_clk); uart_rx = 1'b1;
        repeat (60) @(negedge cpu_clk);
        expect_reg(A_CON, 32'h00000A03, "glitch_con");
        expect_irq(1'b0, "glitch_irq");
    endtask

    task automatic test_div;
        bus_write(A_DIV, 32'd1);
        expect_reg(A_DIV, 32'd2, "div_clamp1");
        bus_write(A_DIV, 32'd0);
        expect_reg(A_DIV, 32'd2, "div_clamp0");
        bus_write(A_DIV, 32'h0001_0007);
        expect_reg(A_DIV, 32'd7, "div_7");
        bus_write(A_DIV, 32'd4);
        expect_reg(A_DIV, 32'd4, "div_4");
    endtask

    task automatic test_reset_midframe;
        int lows;
        bus_write(A_TXD, 32'h00);
        bus_write(A_TXD, 32'h00);
        wait_tx_start("rst_start");
        repeat (8) @(negedge cpu_clk);
        n_cmp++;
        if (uart_tx !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_pre: uart_tx=%b expected 0", uart_tx);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (uart_tx !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_tx: uart_tx=%b expected 1", uart_tx);
        end
        expect_irq(1'b0, "rst_irq");
        @(negedge cpu_clk); reset = 1'b0;
        expect_reg(A_CON, 32'h00000A03, "rst_con");
        lows = 0;
        for (int i = 0; i < 12; i++) begin
            if (uart_tx !== 1'b1) lows++;
            @(negedge cpu_clk);
        end
        n_cmp++;
        if (lows != 0) begin
            n_bad++;
            $display("FAIL rst_idle: low cycles=%0d expected 0", lows);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: sim time expired, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        uart_rx = 1'b1;
        bus.rd = 1'b0; bus.wr = 1'b0;
        bus.addr = '0; bus.wdata = '0;
        repeat (3) @(negedge cpu_clk);
        reset = 1'b0;
        test_reset();
        test_tx_frame();
        test_back_to_back();
        test_rx();
        test_overrun();
        test_frame_err();
        test_div();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_fifo_mmio.md
UART_FIFO_MMIO -- requirements
Module: uart_fifo_mmio

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h40000018, base of the 4-word register window.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, entries per TX and RX FIFO; power of 2, 2..256.
REQ-003 SHALL have parameter CLK_DIV, default 16, reset value of the divisor register; cpu_clk cycles per bit.
REQ-004 SHALL have port cpu_clk  in  1  clock; all logic on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port rd  in  1  read strobe, one access per cycle.
REQ-007 SHALL have port wr  in  1  write strobe; wr has priority if rd and wr are both high.
REQ-008 SHALL have port addr  in  32  byte address.
REQ-009 SHALL have port wdata  in  32  write data.
REQ-010 SHALL have port rdata  out  32  read data; combinational; 0 when rd=0 or address outside window.
REQ-011 SHALL have port uart_rx  in  1  serial input, asynchronous.
REQ-012 SHALL have port uart_tx  out  1  serial output, idle high.
REQ-013 SHALL have port irq  out  1  level interrupt.

Function
REQ-014 Register map SHALL be: BASE+0 TXD (write pushes wdata[7:0]; read returns the last byte pushed); BASE+4 RXD (read returns FIFO head and pops it); BASE+8 CON/STAT; BASE+C DIV (16-bit divisor, value < 2 forced to 2).
REQ-015 CON/STAT bits SHALL be: [0] tx_en, [1] rx_en, [2] tx_irq_en, [3] rx_irq_en (all R/W); read-only [8] tx_full, [9] tx_empty, [10] rx_full, [11] rx_empty, [12] overrun (sticky), [13] frame_err (sticky), [23:16] rx_count.
REQ-016 A CON write with wdata[12]=1 or wdata[13]=1 SHALL clear the corresponding sticky bit; a write with the bit at 0 SHALL leave it unchanged.
REQ-017 A TXD write while tx_full SHALL be dropped; FIFO contents SHALL be unchanged.
REQ-018 An RXD read while rx_empty SHALL return 0 and SHALL NOT pop.
REQ-019 Simultaneous push and pop on one FIFO SHALL both occur and leave the count unchanged, including when full.
REQ-020 TX FSM states SHALL be IDLE, START, DATA, STOP.
REQ-021 TX transitions: IDLE->START when tx_en=1 and TX FIFO is non-empty, popping the head; START, DATA and STOP SHALL each last DIV cycles per bit.
REQ-022 TX frame: uart_tx=0 in START; 8 bits LSB first in DATA; uart_tx=1 in STOP; then IDLE, or START next cycle if data is pending.
REQ-023 Clearing tx_en mid-frame SHALL let the current frame finish; no new frame SHALL start.
REQ-024 uart_rx SHALL pass through a 2-flop synchroniser before use.
REQ-025 RX FSM states SHALL be IDLE, START, DATA, STOP.
REQ-026 RX transitions: IDLE->START on a synchronised falling edge when rx_en=1; START checks the line at DIV/2; if the line is high, return to IDLE (glitch); else DATA samples 8 bits at mid-bit spacing of DIV; STOP samples at mid-bit.
REQ-027 A stop bit of 1 with RX FIFO not full SHALL push the byte.
REQ-028 A stop bit of 1 with RX FIFO full SHALL drop the byte and set overrun.
REQ-029 A stop bit of 0 SHALL drop the byte and set frame_err.
REQ-030 A DIV write SHALL take effect at the next bit boundary.
REQ-031 irq SHALL equal (tx_irq_en & tx_empty & tx FSM IDLE) | (rx_irq_en & ~rx_empty) | overrun | frame_err.

Reset
REQ-032 Reset SHALL set: uart_tx=1; irq=0; CON=0x03 (tx_en=1, rx_en=1, irq enables 0); DIV=CLK_DIV; both FIFOs empty; sticky bits 0; both FSMs IDLE; TXD shadow 0.
REQ-033 Reset asserted mid-frame SHALL abort the frame immediately; uart_tx=1 within the reset assertion.

Structure
REQ-034 A shared package SHALL hold register offsets, CON/STAT bit indices and the FSM state enum for TX and RX.
REQ-035 Both FIFOs SHALL be instances of one sub-module, uart_sync_fifo (params WIDTH, DEPTH; ports push, pop, din, dout, full, empty, count).

Verification (CLK_DIV=4, FIFO_DEPTH=4)
REQ-036 Write 0xA5 to TXD -> uart_tx shows 0,1,0,1,0,0,1,0,1,1, 4 cycles per bit, 40 cycles total; tx_empty then 1.
REQ-037 Write 0x01..0x05 to TXD back-to-back -> 5th write dropped; 4 frames sent with no idle gap between them.
REQ-038 Drive serial 0x3C on uart_rx -> rx_count=1; RXD read returns 0x3C; rx_empty=1; 2nd RXD read returns 0.
REQ-039 Send 5 frames with no reads -> FIFO holds first 4; overrun=1; irq=1; CON write 0x1003 -> overrun=0.
REQ-040 Frame with stop bit=0; 1-cycle low glitch on uart_rx -> frame_err=1 with no push; glitch causes no frame and no push.
REQ-041 Assert reset mid-DATA of a TX frame -> uart_tx=1 immediately; CON reads 0x00000A03 (tx_empty, rx_empty set).
